// File: rtl/conv_stream_filter.sv
// conv_stream_filter: streaming KxK 2-D convolution over a raster-order frame, zero-padded borders,
// Latency: output n is presented 2 advance cycles after the input pixel / flush token that launches it.
// Backpressure: a single global stall (advance = !o_y_valid || i_y_ready) freezes every stage and input.
//
// Ports:
//   i_clk, i_rst        rising-edge clock, synchronous active-high reset
//   i_x_valid/o_x_ready input pixel handshake, i_x_data unsigned W-bit pixel
//   o_y_valid/i_y_ready output pixel handshake, o_y_data W-bit filtered pixel
//   i_kernel_flat       K*K signed KW-bit taps, row-major, tap [0][0] at LSBs (latched on pixel 0)
//   i_norm_shift        arithmetic right shift of the accumulator (latched on pixel 0)
//   o_busy              first accepted pixel .. last output accepted
//   o_frame_done        one-cycle pulse after output N-1 is accepted
//
// Optional build macro CONV_ABS_EN: the shifted value is replaced by its magnitude before the clamp,
// so negative responses (edge detectors) map to |v| instead of 0.

module conv_stream_filter #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int K          = 3,
    parameter int W          = 8,
    parameter int KW         = 8,
    parameter int SHW        = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_x_valid,
    output logic              o_x_ready,
    input  logic [W-1:0]      i_x_data,
    output logic              o_y_valid,
    input  logic              i_y_ready,
    output logic [W-1:0]      o_y_data,
    input  logic [K*K*KW-1:0] i_kernel_flat,
    input  logic [SHW-1:0]    i_norm_shift,
    output logic              o_busy,
    output logic              o_frame_done
);
    localparam int R     = K / 2;
    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int L     = R * IMG_WIDTH + R;
    localparam int NT    = K * K;
    localparam int PW    = W + 1 + KW;
    localparam int ACC_W = W + KW + $clog2(NT) + 1;
    localparam int CW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int NCW   = $clog2(N + 1);
    localparam int TCW   = $clog2(L + 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH} state_t;

    // control state
    state_t            r_state;
    logic [NCW-1:0]    r_in_cnt;
    logic [NCW-1:0]    r_out_cnt;
    logic [TCW-1:0]    r_tok_cnt;
    logic              r_tok_done;
    logic [CW-1:0]     r_col;
    logic [CW-1:0]     r_lcol;
    logic [RW-1:0]     r_lrow;
    logic [CW-1:0]     r_wcol;
    logic [RW-1:0]     r_wrow;
    logic [K*K*KW-1:0] r_coef;
    logic [SHW-1:0]    r_shift;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_w_vld;
    logic              r_p_vld;
    logic              r_y_valid;
    logic [W-1:0]      r_y_data;

    // datapath storage (never reset: border masking keeps stale contents out of the result)
    logic [W-1:0]         r_lb   [K-1][IMG_WIDTH];
    logic [W-1:0]         r_win  [K][K];
    logic signed [PW-1:0] r_prod [NT];

    logic                    w_advance;
    logic                    w_x_acc;
    logic                    w_tok;
    logic                    w_shift;
    logic                    w_launch;
    logic                    w_y_acc;
    logic [W-1:0]            w_new_pix;
    logic [W-1:0]            w_lb_rd [K-1];
    logic [W-1:0]            w_colv  [K];
    logic [W-1:0]            w_tap   [NT];
    logic signed [PW-1:0]    w_prod  [NT];
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_sh;
    logic signed [ACC_W-1:0] w_mag;
    logic [W-1:0]            w_clamp;

    assign w_advance = !r_y_valid || i_y_ready;
    assign o_x_ready = w_advance && (r_state != S_FLUSH) && !i_rst;
    assign w_x_acc   = i_x_valid && o_x_ready;
    // flush tokens keep the window moving after the last real pixel so the tail outputs get launched
    assign w_tok     = w_advance && (r_state == S_FLUSH) && !r_tok_done && !i_rst;
    assign w_shift   = w_x_acc || w_tok;
    assign w_launch  = w_tok || (w_x_acc && (r_state == S_RUN));
    assign w_y_acc   = r_y_valid && i_y_ready;
    assign w_new_pix = w_tok ? '0 : i_x_data;

    assign o_y_valid    = r_y_valid;
    assign o_y_data     = r_y_data;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

    // line buffer k returns the pixel (k+1) rows above the one being shifted in
    always_comb begin
        for (int k = 0; k < K-1; k++) begin
            w_lb_rd[k] = r_lb[k][r_col];
        end
    end

    // new window column: bottom row is the incoming pixel, rows above come from the line buffers
    always_comb begin
        for (int i = 0; i < K; i++) begin
            w_colv[i] = '0;
        end
        w_colv[K-1] = w_new_pix;
        for (int k = 1; k < K; k++) begin
            w_colv[K-1-k] = w_lb_rd[k-1];
        end
    end

    function automatic logic tap_in_frame(input int row, input int col);
        return (row >= 0) && (row < IMG_HEIGHT) && (col >= 0) && (col < IMG_WIDTH);
    endfunction

    // Window column j of row i is the source pixel (wrow+i-R, wcol+j-R) only when that lies inside
    // the frame; near the left/right edges the window holds wrapped pixels of the adjacent row.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w_tap[i*K+j] = tap_in_frame(int'(r_wrow) + i - R, int'(r_wcol) + j - R)
                             ? r_win[i][j] : '0;
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NT; t++) begin
            w_prod[t] = PW'($signed({1'b0, w_tap[t]})) * PW'($signed(r_coef[t*KW +: KW]));
        end
    end

    // stage 2: adder tree, floor shift, optional magnitude, clamp to 0..2^W-1
    always_comb begin
        w_acc = '0;
        for (int t = 0; t < NT; t++) begin
            w_acc = w_acc + ACC_W'(r_prod[t]);
        end
        w_sh = w_acc >>> r_shift;
`ifdef CONV_ABS_EN
        w_mag = w_sh[ACC_W-1] ? -w_sh : w_sh;
`else
        w_mag = w_sh;
`endif
        if (w_mag[ACC_W-1]) begin
            w_clamp = '0;
        end else if (w_mag > MAXV) begin
            w_clamp = '1;
        end else begin
            w_clamp = w_mag[W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_shift) begin
            r_lb[0][r_col] <= w_new_pix;
            for (int k = 1; k < K-1; k++) begin
                r_lb[k][r_col] <= w_lb_rd[k-1];
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-1; j++) begin
                    r_win[i][j] <= r_win[i][j+1];
                end
                r_win[i][K-1] <= w_colv[i];
            end
        end
        if (w_advance) begin
            for (int t = 0; t < NT; t++) begin
                r_prod[t] <= w_prod[t];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_tok_cnt    <= '0;
            r_tok_done   <= 1'b0;
            r_col        <= '0;
            r_lcol       <= '0;
            r_lrow       <= '0;
            r_wcol       <= '0;
            r_wrow       <= '0;
            r_coef       <= '0;
            r_shift      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_w_vld      <= 1'b0;
            r_p_vld      <= 1'b0;
            r_y_valid    <= 1'b0;
            r_y_data     <= '0;
        end else begin
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_x_acc) begin
                        r_coef     <= i_kernel_flat;
                        r_shift    <= i_norm_shift;
                        r_busy     <= 1'b1;
                        r_in_cnt   <= NCW'(1);
                        r_out_cnt  <= '0;
                        r_lrow     <= '0;
                        r_lcol     <= '0;
                        r_tok_cnt  <= '0;
                        r_tok_done <= 1'b0;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_x_acc) begin
                        r_in_cnt <= r_in_cnt + NCW'(1);
                        if (r_in_cnt == NCW'(L-1)) begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_x_acc) begin
                        r_in_cnt <= r_in_cnt + NCW'(1);
                        if (r_in_cnt == NCW'(N-1)) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_tok) begin
                        r_tok_cnt <= r_tok_cnt + TCW'(1);
                        if (r_tok_cnt == TCW'(L-1)) begin
                            r_tok_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // frame ends when the last output leaves, which is always after the last flush token
            if (w_y_acc) begin
                if (r_out_cnt == NCW'(N-1)) begin
                    r_out_cnt    <= '0;
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end else begin
                    r_out_cnt <= r_out_cnt + NCW'(1);
                end
            end

            // position of the output carried by the window being loaded on this shift
            if (w_launch) begin
                r_wrow <= r_lrow;
                r_wcol <= r_lcol;
                if (r_lcol == CW'(IMG_WIDTH-1)) begin
                    r_lcol <= '0;
                    r_lrow <= (r_lrow == RW'(IMG_HEIGHT-1)) ? '0 : r_lrow + RW'(1);
                end else begin
                    r_lcol <= r_lcol + CW'(1);
                end
            end

            // line-buffer pointer only needs to be consistent within a frame
            if (w_shift) begin
                r_col <= (r_col == CW'(IMG_WIDTH-1)) ? '0 : r_col + CW'(1);
            end

            if (w_advance) begin
                r_w_vld   <= w_launch;
                r_p_vld   <= r_w_vld;
                r_y_valid <= r_p_vld;
                if (r_p_vld) begin
                    r_y_data <= w_clamp;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_filter.sv
module tb_conv_stream_filter;
    localparam int IW   = 8;
    localparam int IH   = 6;
    localparam int K    = 3;
    localparam int W    = 8;
    localparam int KW   = 8;
    localparam int SHW  = 4;
    localparam int NPIX = IW * IH;
    localparam int NVEC = 23;
`ifdef CONV_ABS_EN
    localparam int NEG_EXP = 255;
`else
    localparam int NEG_EXP = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              x_valid;
    logic              x_ready;
    logic [W-1:0]      x_data;
    logic              y_valid;
    logic              y_ready;
    logic [W-1:0]      y_data;
    logic [K*K*KW-1:0] kernel_flat;
    logic [SHW-1:0]    norm_shift;
    logic              busy;
    logic              frame_done;

    always #5 clk = ~clk;

    conv_stream_filter #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .K(K), .W(W), .KW(KW), .SHW(SHW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_x_valid(x_valid), .o_x_ready(x_ready), .i_x_data(x_data),
        .o_y_valid(y_valid), .i_y_ready(y_ready), .o_y_data(y_data),
        .i_kernel_flat(kernel_flat), .i_norm_shift(norm_shift),
        .o_busy(busy), .o_frame_done(frame_done)
    );

    typedef struct {
        int run;
        int idx;
        int exp;
    } vec_t;

    typedef struct {
        int kern;
        int shift;
        int img;
    } run_t;

    vec_t vt [NVEC];
    run_t runs [3];
    int   res [3][NPIX];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int q[$];
    int fd_cnt, first_v, acc9, stab_err, busy_err;
    int fpix [NPIX];
    int sw_at = -1;
    logic [K*K*KW-1:0] sw_kernel;
    bit   rdy_rand = 1'b0;
    bit   in_gaps  = 1'b0;
    bit   held     = 1'b0;
    logic [W-1:0] held_dat;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [K*K*KW-1:0] kern(input int id);
        logic [K*K*KW-1:0] k;
        int c;
        k = '0;
        for (int t = 0; t < K*K; t++) begin
            case (id)
                0:       c = (t == 4) ? 1 : 0;
                1:       c = 1;
                2:       c = (t < 3) ? ((t == 1) ? -2 : -1) : ((t > 5) ? ((t == 7) ? 2 : 1) : 0);
                default: c = 0;
            endcase
            k[t*KW +: KW] = KW'(c);
        end
        return k;
    endfunction

    function automatic int img_pix(input int img, input int idx);
        case (img)
            0:       return idx;
            1:       return 100;
            default: return ((idx / IW) < 3) ? 0 : 200;
        endcase
    endfunction

    task automatic load_img(input int img);
        for (int i = 0; i < NPIX; i++) fpix[i] = img_pix(img, i);
    endtask

    always @(posedge clk) cyc++;

    // output collector, stall-stability and frame_done/busy observer
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held && (!y_valid || y_data !== held_dat)) stab_err++;
            held     = y_valid && !y_ready;
            held_dat = y_data;
            if (y_valid && first_v < 0) first_v = cyc;
            if (y_valid && y_ready) q.push_back(int'(y_data));
            if (frame_done) begin
                fd_cnt++;
                if (busy) busy_err++;
            end
        end
    end

    initial begin
        y_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            y_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic start_run();
        q.delete();
        fd_cnt   = 0;
        first_v  = -1;
        acc9     = -100;
        stab_err = 0;
        busy_err = 0;
    endtask

    task automatic send_pixels(input int npix);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < npix && guard < 4000) begin
            @(posedge clk);
            #1;
            if (i == sw_at) kernel_flat = sw_kernel;
            if (in_gaps && $urandom_range(0, 2) == 0) begin
                x_valid = 1'b0;
            end else begin
                x_valid = 1'b1;
                x_data  = W'(fpix[i]);
            end
            @(negedge clk);
            if (x_valid && x_ready) begin
                if (i == 9) acc9 = cyc + 1;
                i++;
            end
            guard++;
        end
        chk("send_accept", i, npix);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int guard;
        guard = 0;
        while ((q.size() < NPIX || fd_cnt < 1) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        chk({name, "_count"}, q.size(), NPIX);
        chk({name, "_frame_done"}, fd_cnt, 1);
    endtask

    task automatic chk_seq(input string name, input int ident);
        for (int i = 0; i < NPIX; i++) begin
            chk($sformatf("%s_out%0d", name, i), (i < q.size()) ? q[i] : -1, ident ? i : 0);
        end
    endtask

    initial begin
        // vector table: {run, output index, expected pixel}
        runs[0] = '{1, 0, 1};
        runs[1] = '{1, 3, 1};
        runs[2] = '{2, 0, 2};
        vt[0]  = '{0, 0, 255};    vt[1]  = '{0, 9, 255};    vt[2]  = '{0, 47, 255};
        vt[3]  = '{1, 0, 50};     vt[4]  = '{1, 7, 50};     vt[5]  = '{1, 40, 50};
        vt[6]  = '{1, 47, 50};    vt[7]  = '{1, 1, 75};     vt[8]  = '{1, 8, 75};
        vt[9]  = '{1, 15, 75};    vt[10] = '{1, 44, 75};    vt[11] = '{1, 9, 112};
        vt[12] = '{1, 27, 112};
        vt[13] = '{2, 3, 0};      vt[14] = '{2, 12, 0};     vt[15] = '{2, 16, 255};
        vt[16] = '{2, 20, 255};   vt[17] = '{2, 23, 255};   vt[18] = '{2, 24, 255};
        vt[19] = '{2, 31, 255};   vt[20] = '{2, 35, 0};     vt[21] = '{2, 42, NEG_EXP};
        vt[22] = '{2, 47, NEG_EXP};

        rst = 1'b1;
        x_valid = 1'b0;
        x_data = '0;
        kernel_flat = '0;
        norm_shift = '0;
        sw_kernel = '0;
        start_run();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x_ready", int'(x_ready), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_y_data", int'(y_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // identity on the ramp, no stalls
        kernel_flat = kern(0);
        norm_shift = '0;
        load_img(0);
        start_run();
        send_pixels(NPIX);
        chk("busy_mid", int'(busy), 1);
        chk("x_ready_flush", int'(x_ready), 0);
        wait_frame("ident");
        chk_seq("ident", 1);
        chk("latency", first_v - acc9, 2);
        chk("busy_end", int'(busy), 0);
        chk("busy_with_done", busy_err, 0);

        // table-driven box / Sobel runs
        for (int r = 0; r < 3; r++) begin
            kernel_flat = kern(runs[r].kern);
            norm_shift = SHW'(runs[r].shift);
            load_img(runs[r].img);
            start_run();
            send_pixels(NPIX);
            wait_frame($sformatf("tbl%0d", r));
            for (int i = 0; i < NPIX; i++) res[r][i] = (i < q.size()) ? q[i] : -1;
        end
        for (int v = 0; v < NVEC; v++) begin
            chk($sformatf("vec%0d_run%0d_idx%0d", v, vt[v].run, vt[v].idx),
                res[vt[v].run][vt[v].idx], vt[v].exp);
        end

        // random output stalls plus input gaps
        kernel_flat = kern(0);
        norm_shift = '0;
        load_img(0);
        rdy_rand = 1'b1;
        in_gaps = 1'b1;
        start_run();
        send_pixels(NPIX);
        wait_frame("stall");
        chk_seq("stall", 1);
        chk("stall_hold", stab_err, 0);
        rdy_rand = 1'b0;
        in_gaps = 1'b0;
        repeat (3) @(posedge clk);

        // kernel changed to all-zero after 10 pixels: takes effect on next frame only
        sw_at = 10;
        sw_kernel = kern(3);
        start_run();
        send_pixels(NPIX);
        wait_frame("switch");
        chk_seq("switch", 1);
        sw_at = -1;
        start_run();
        send_pixels(NPIX);
        wait_frame("zero");
        chk_seq("zero", 0);

        // reset after 20 pixels, then a clean frame
        kernel_flat = kern(0);
        start_run();
        send_pixels(20);
        rst = 1'b1;
        start_run();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_pixels(NPIX);
        wait_frame("abort");
        chk_seq("abort", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
